axi_stream_remove_header: RTL and testbench

- Downstream companion of the header-insert stage: strips a per-packet number of leading bytes from an AXI-Stream packet and re-packs the rest onto the bus.
- Output beats are packed contiguously with no holes. Used at the receive side to drop an inserted header before payload processing.
- Byte order: byte lane DATA_BYTE_WD-1 (MSBs) is the first byte of a beat. The last-beat keep is MSB-aligned contiguous ones (e.g. 4'b1100).

---
 rtl/axi_stream_remove_header.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_stream_remove_header.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_remove_header.sv
// Strips N leading bytes from each AXI-Stream packet and re-packs the remainder MSB-first.
// Optional macro REMOVE_HDR_CAPTURE_EN adds header_out/header_valid.
module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_remove,
  input  logic [BYTE_CNT_WD-1:0]  byte_remove,
  output logic                    ready_remove
`ifdef REMOVE_HDR_CAPTURE_EN
  ,
  output logic [DATA_WD-1:0]      header_out,
  output logic                    header_valid
`endif
);

  localparam int CW = BYTE_CNT_WD + 1;
  localparam int SW = BYTE_CNT_WD + 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FIRST  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  function automatic logic [DATA_BYTE_WD-1:0] f_keep(input logic [CW-1:0] cnt);
    logic [DATA_BYTE_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[DATA_BYTE_WD-1-i] = (CW'(i) < cnt);
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] f_lanes(input logic [DATA_BYTE_WD-1:0] keep);
    logic [DATA_WD-1:0] d;
    d = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) d[8*i +: 8] = {8{keep[i]}};
    return d;
  endfunction

  function automatic logic [CW-1:0] f_count(input logic [DATA_BYTE_WD-1:0] keep);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CW'(keep[i]);
    return c;
  endfunction

  logic [1:0]              r_state, w_state_nxt;
  logic [BYTE_CNT_WD-1:0]  r_n, w_n_nxt;
  logic [DATA_WD-1:0]      r_prev;
  logic [CW-1:0]           r_flush_cnt, w_flush_cnt_nxt;
  logic                    r_valid_out, r_last_out;
  logic [DATA_WD-1:0]      r_data_out;
  logic [DATA_BYTE_WD-1:0] r_keep_out;

  logic                    w_out_free, w_in_fire, w_rm_fire, w_prev_ld;
  logic                    w_emit, w_emit_last;
  logic [DATA_WD-1:0]      w_emit_data, w_str_data, w_fl_data, w_first_data;
  logic [CW-1:0]           w_emit_cnt, w_k, w_n_ext, w_full;
  logic [DATA_BYTE_WD-1:0] w_emit_keep;
  logic [BYTE_CNT_WD+2:0]  w_shamt;
  logic [SW-1:0]           w_rshamt;

  assign w_out_free   = !r_valid_out || ready_out;
  assign ready_in     = ((r_state == S_FIRST) || (r_state == S_STREAM)) && w_out_free;
  assign ready_remove = (r_state == S_IDLE);
  assign w_in_fire    = valid_in && ready_in;
  assign w_rm_fire    = valid_remove && ready_remove;
  assign w_k          = f_count(keep_in);
  assign w_n_ext      = {1'b0, r_n};
  assign w_full       = CW'(DATA_BYTE_WD);
  assign w_shamt      = {r_n, 3'b000};
  assign w_rshamt     = SW'(DATA_WD) - SW'(w_shamt);
  // Residual is the previous beat's low bytes; the new beat supplies the top N bytes.
  assign w_str_data   = (r_prev << w_shamt) | (data_in >> w_rshamt);
  assign w_fl_data    = r_prev << w_shamt;
  assign w_first_data = data_in << w_shamt;
  assign w_emit_keep  = f_keep(w_emit_cnt);

  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;
  assign keep_out  = r_keep_out;
  assign last_out  = r_last_out;

  // Next-state, output-beat and residual bookkeeping
  always_comb begin
    w_state_nxt     = r_state;
    w_n_nxt         = r_n;
    w_flush_cnt_nxt = r_flush_cnt;
    w_prev_ld       = 1'b0;
    w_emit          = 1'b0;
    w_emit_data     = '0;
    w_emit_cnt      = '0;
    w_emit_last     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rm_fire) begin
          w_n_nxt     = byte_remove;
          w_state_nxt = S_FIRST;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FIRST: begin
        if (w_in_fire) begin
          w_prev_ld = 1'b1;
          if (last_in) begin
            w_state_nxt = S_IDLE;
            if (w_k > w_n_ext) begin
              w_emit      = 1'b1;
              w_emit_data = w_first_data;
              w_emit_cnt  = w_k - w_n_ext;
              w_emit_last = 1'b1;
            end else begin
              w_emit = 1'b0;
            end
          end else begin
            w_state_nxt = S_STREAM;
            if (r_n == '0) begin
              w_emit      = 1'b1;
              w_emit_data = data_in;
              w_emit_cnt  = w_full;
            end else begin
              w_emit = 1'b0;
            end
          end
        end else begin
          w_state_nxt = S_FIRST;
        end
      end
      S_STREAM: begin
        if (w_in_fire) begin
          w_prev_ld = 1'b1;
          w_emit    = 1'b1;
          if (r_n == '0) begin
            w_emit_data = data_in;
            w_emit_cnt  = w_k;
            w_emit_last = last_in;
            w_state_nxt = last_in ? S_IDLE : S_STREAM;
          end else if (!last_in) begin
            w_emit_data = w_str_data;
            w_emit_cnt  = w_full;
          end else if (w_k <= w_n_ext) begin
            w_emit_data = w_str_data;
            w_emit_cnt  = w_full - w_n_ext + w_k;
            w_emit_last = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_emit_data     = w_str_data;
            w_emit_cnt      = w_full;
            w_flush_cnt_nxt = w_k - w_n_ext;
            w_state_nxt     = S_FLUSH;
          end
        end else begin
          w_state_nxt = S_STREAM;
        end
      end
      S_FLUSH: begin
        if (w_out_free) begin
          w_emit          = 1'b1;
          w_emit_data     = w_fl_data;
          w_emit_cnt      = r_flush_cnt;
          w_emit_last     = 1'b1;
          w_flush_cnt_nxt = '0;
          w_state_nxt     = S_IDLE;
        end else begin
          w_state_nxt = S_FLUSH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Control state, strip count and residual registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_prev      <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_n         <= w_n_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      if (w_prev_ld) r_prev <= data_in;
    end
  end

  // Output beat register; holds while stalled, unused lanes forced to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_keep_out  <= '0;
      r_last_out  <= 1'b0;
    end else if (w_emit) begin
      r_valid_out <= 1'b1;
      r_data_out  <= w_emit_data & f_lanes(w_emit_keep);
      r_keep_out  <= w_emit_keep;
      r_last_out  <= w_emit_last;
    end else if (ready_out) begin
      r_valid_out <= 1'b0;
    end
  end

`ifdef REMOVE_HDR_CAPTURE_EN
  // Capture stripped header bytes from the first beat of each packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      header_out   <= '0;
      header_valid <= 1'b0;
    end else if ((r_state == S_FIRST) && w_in_fire && (r_n != '0)) begin
      header_out   <= data_in & f_lanes(f_keep(w_n_ext));
      header_valid <= 1'b1;
    end else begin
      header_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Scoreboard bench for axi_stream_remove_header: byte-queue reference model, decoupled monitor.
module tb_axi_stream_remove_header;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [BW-1:0] keep_in = '0;
  logic          last_in = 1'b0;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [BW-1:0] keep_out;
  logic          last_out;
  logic          ready_out = 1'b1;
  logic          valid_remove = 1'b0;
  logic [CW-1:0] byte_remove = '0;
  logic          ready_remove;

  axi_stream_remove_header #(.DATA_WD(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out),
    .valid_remove(valid_remove), .byte_remove(byte_remove), .ready_remove(ready_remove)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [BW-1:0] keep;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         mon_b;
  logic [DW-1:0] pkt_data[$];
  logic [BW-1:0] pkt_keep[$];
  int            errors = 0;
  int            checks = 0;
  int            out_cnt = 0;
  int            rdy_mode = 0;
  int            stall_base = 0;
  int            stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: flatten valid bytes, drop the first n, pack MSB-first into beats.
  task automatic model_push(input int n);
    logic [7:0] bytes[$];
    beat_t      b;
    for (int i = 0; i < pkt_data.size(); i++)
      for (int j = 0; j < BW; j++)
        if (pkt_keep[i][BW-1-j]) bytes.push_back(pkt_data[i][DW-1-8*j -: 8]);
    for (int i = 0; i < n && bytes.size() > 0; i++) void'(bytes.pop_front());
    while (bytes.size() > 0) begin
      b = '0;
      for (int j = 0; j < BW && bytes.size() > 0; j++) begin
        b.data[DW-1-8*j -: 8] = bytes.pop_front();
        b.keep[BW-1-j] = 1'b1;
      end
      b.last = (bytes.size() == 0);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_pkt(input int n, input int max_beats, input bit gaps);
    int t;
    valid_remove = 1'b1;
    byte_remove  = CW'(n);
    t = 0;
    @(negedge clk);
    while (!ready_remove && t < 200) begin @(negedge clk); t++; end
    chk("remove_handshake", 64'(ready_remove), 64'd1);
    @(posedge clk); #1;
    valid_remove = 1'b0;
    if (max_beats >= pkt_data.size()) model_push(n);
    for (int i = 0; i < pkt_data.size() && i < max_beats; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      valid_in = 1'b1;
      data_in  = pkt_data[i];
      keep_in  = pkt_keep[i];
      last_in  = (i == pkt_data.size() - 1);
      t = 0;
      @(negedge clk);
      while (!ready_in && t < 200) begin @(negedge clk); t++; end
      chk("input_handshake", 64'(ready_in), 64'd1);
      @(posedge clk); #1;
      valid_in = 1'b0;
      last_in  = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || valid_out) && t < 1000) begin @(posedge clk); #1; t++; end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic load_plan_stream();
    pkt_data = {32'hAABBCCDD, 32'hEEFF0011, 32'h22334455, 32'h00AABBCC};
    pkt_keep = {4'b1111, 4'b1111, 4'b1111, 4'b1100};
  endtask

  // Monitor: pop on handshake, verify hold and ready_in while stalled
  always @(negedge clk) begin
    if (rst_n && valid_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %h/%b/%b expected no beat", data_out, keep_out, last_out);
      end else if (ready_out) begin
        mon_b = exp_q.pop_front();
        chk("out_beat", 64'({data_out, keep_out, last_out}), 64'(mon_b));
        out_cnt++;
      end else begin
        chk("stall_hold", 64'({data_out, keep_out, last_out}), 64'(exp_q[0]));
        chk("stall_ready_in", 64'(ready_in), 64'd0);
      end
    end
  end

  // Downstream ready generator
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: ready_out = 1'($urandom_range(0, 1));
      2: begin
        if (out_cnt == stall_base + 1 && stall_cnt < 3) begin
          ready_out = 1'b0;
          stall_cnt++;
        end else begin
          ready_out = 1'b1;
        end
      end
      default: begin
        ready_out = 1'b1;
        stall_cnt = 0;
      end
    endcase
  end

  initial begin
    #1;
    chk("reset_outputs", 64'({ready_in, valid_out, data_out, keep_out, last_out, ready_remove}),
        64'({1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1}));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 4; n++) begin
      load_plan_stream();
      send_pkt(n, 99, 1'b0);
      drain();
    end

    pkt_data = {32'h00AABBCC};
    pkt_keep = {4'b1100};
    send_pkt(3, 99, 1'b0);
    chk("strip_all_ready_remove", 64'(ready_remove), 64'd1);
    chk("strip_all_no_valid", 64'(valid_out), 64'd0);
    drain();
    send_pkt(1, 99, 1'b0);
    drain();

    stall_base = out_cnt;
    rdy_mode   = 2;
    load_plan_stream();
    send_pkt(1, 99, 1'b0);
    drain();
    rdy_mode = 0;
    @(posedge clk); #1;

    load_plan_stream();
    send_pkt(1, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midpkt_reset_outputs", 64'({ready_in, valid_out, data_out, keep_out, last_out, ready_remove}),
        64'({1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1}));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pkt_data = {32'h11223344, 32'h55667788};
    pkt_keep = {4'b1111, 4'b1111};
    send_pkt(2, 99, 1'b0);
    drain();

    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      int nb;
      int k;
      nb = $urandom_range(1, 4);
      pkt_data.delete();
      pkt_keep.delete();
      for (int b = 0; b < nb; b++) begin
        pkt_data.push_back(DW'($urandom));
        pkt_keep.push_back(4'b1111);
      end
      k = $urandom_range(1, 4);
      pkt_keep[nb-1] = BW'(4'b1111 << (4 - k));
      send_pkt($urandom_range(0, 3), 99, 1'b1);
    end
    rdy_mode = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
